// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } frame_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Valid/ready payload stream leaving the frame controller.
interface uart_rx_frame_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/uart_frame_fifo.sv
// Payload FIFO with a commit pointer: only words below the commit pointer are
// visible to the reader; rewind drops everything written since the last commit.
module uart_frame_fifo #(
  parameter int DBITS      = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [DBITS:0]   wr_data,
  input  logic             commit,
  input  logic             rewind,
  input  logic             rd_en,
  output logic [DBITS-1:0] head_data,
  output logic             head_last,
  output logic             head_valid,
  output logic [AW:0]      count,
  output logic             full
);

  logic [DBITS:0] mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, cm_ptr;
  logic [AW:0]    wr_nxt, rd_nxt, cm_nxt;

  always_comb begin
    wr_nxt = wr_ptr;
    if (rewind)     wr_nxt = cm_ptr;
    else if (wr_en) wr_nxt = wr_ptr + (AW+1)'(1);
    cm_nxt = commit ? wr_ptr : cm_ptr;
    rd_nxt = rd_en ? rd_ptr + (AW+1)'(1) : rd_ptr;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = cm_ptr - rd_ptr;

  always_ff @(posedge clk_100MHz) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Head is registered from next-state pointers; a committed slot is never
  // the one being written in the same cycle.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cm_ptr     <= '0;
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      cm_ptr     <= cm_nxt;
      head_valid <= (cm_nxt != rd_nxt);
      {head_last, head_data} <= (cm_nxt != rd_nxt) ? mem[rd_nxt[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser between uart_receiver and application logic: header, payload, checksum.
// Optional inter-word timeout enabled by defining UART_FRAME_TIMEOUT_EN.
//   state   | meaning
//   HUNT    | waiting for a header word, counting noise
//   PAYLOAD | storing L payload words, accumulating sum
//   CHECK   | waiting for the checksum word
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int DBITS         = 16,
  parameter int MAX_LEN       = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  rx_ready,
  input  logic [DBITS-1:0]      rx_data,
  input  logic                  sample_tick,
  uart_rx_frame_ctrl_if.master  out_if,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  frame_state_e     state_q, state_d;
  logic [7:0]       len_q, cnt_q;
  logic [DBITS-1:0] sum_q;
  logic             is_hdr, len_ok, is_last, tmo_hit;
  logic             fifo_wr, fifo_commit, fifo_rewind, fifo_full, pop;
  logic             done_d, err_d, drop_inc;
  logic [1:0]       code_d;
  logic [AW:0]      fifo_count;
  logic [DBITS-1:0] head_data;
  logic             head_last, head_valid;

  assign is_hdr  = (rx_data[DBITS-1 -: 8] == HDR_MAGIC);
  assign len_ok  = (rx_data[7:0] != 8'd0) && (rx_data[7:0] <= 8'(MAX_LEN));
  assign is_last = ((cnt_q + 8'd1) == len_q);
  assign pop     = out_if.out_ready && (fifo_count != '0);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_cnt;

  // Down-counter reloaded by every word; terminal count fires on the last tick.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)                                tmo_cnt <= '0;
    else if (rx_ready)                           tmo_cnt <= TW'(TIMEOUT_TICKS);
    else if (sample_tick && state_q != HUNT)     tmo_cnt <= tmo_cnt - TW'(1);
  end

  assign tmo_hit = (state_q != HUNT) && !rx_ready && sample_tick && (tmo_cnt == TW'(1));
`else
  logic unused_sample_tick;
  assign unused_sample_tick = sample_tick;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (rx_ready && is_hdr && len_ok) state_d = PAYLOAD;
      PAYLOAD: if (tmo_hit)                      state_d = HUNT;
               else if (rx_ready && fifo_full)   state_d = HUNT;
               else if (rx_ready && is_last)     state_d = CHECK;
      CHECK:   if (tmo_hit || rx_ready)          state_d = HUNT;
      default:                                   state_d = HUNT;
    endcase
  end

  always_comb begin
    fifo_wr     = 1'b0;
    fifo_commit = 1'b0;
    fifo_rewind = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    drop_inc    = 1'b0;
    code_d      = err_code;
    case (state_q)
      HUNT: if (rx_ready) begin
        if (!is_hdr)     drop_inc = 1'b1;
        else if (!len_ok) begin err_d = 1'b1; code_d = ERR_LEN; end
      end
      PAYLOAD: begin
        if (tmo_hit) begin
          fifo_rewind = 1'b1; err_d = 1'b1; code_d = ERR_TMO;
        end else if (rx_ready) begin
          if (fifo_full) begin
            fifo_rewind = 1'b1; err_d = 1'b1; code_d = ERR_OVF;
          end else fifo_wr = 1'b1;
        end
      end
      CHECK: begin
        if (tmo_hit) begin
          fifo_rewind = 1'b1; err_d = 1'b1; code_d = ERR_TMO;
        end else if (rx_ready) begin
          if (rx_data == sum_q) begin
            fifo_commit = 1'b1; done_d = 1'b1;
          end else begin
            fifo_rewind = 1'b1; err_d = 1'b1; code_d = ERR_CSUM;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= ERR_LEN;
      busy        <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (state_q == HUNT && rx_ready && is_hdr && len_ok) begin
        len_q <= rx_data[7:0];
        cnt_q <= '0;
        sum_q <= '0;
      end else if (fifo_wr) begin
        cnt_q <= cnt_q + 8'd1;
        sum_q <= sum_q + rx_data;
      end
      frame_done  <= done_d;
      frame_error <= err_d;
      err_code    <= code_d;
      busy        <= (state_d != HUNT);
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  uart_frame_fifo #(.DBITS(DBITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .wr_en      (fifo_wr),
    .wr_data    ({is_last, rx_data}),
    .commit     (fifo_commit),
    .rewind     (fifo_rewind),
    .rd_en      (pop),
    .head_data  (head_data),
    .head_last  (head_last),
    .head_valid (head_valid),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  assign out_if.out_data  = head_data;
  assign out_if.out_last  = head_last;
  assign out_if.out_valid = head_valid;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (MAX_LEN=8, FIFO_DEPTH=8, TIMEOUT_TICKS=16).
module tb_uart_rx_frame_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  logic        rx_ready   = 1'b0;
  logic [15:0] rx_data    = '0;
  logic        sample_tick = 1'b0;
  logic        frame_done, frame_error, busy;
  logic [1:0]  err_code;
  logic [7:0]  drop_cnt;
  logic        rdy_lvl = 1'b0;
  logic        tog_en  = 1'b0;
  logic        tog     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit valid_seen = 1'b0;
  logic [16:0] got_q [$];

  uart_rx_frame_ctrl_if #(.DBITS(16)) bus ();

  assign bus.out_ready = tog_en ? tog : rdy_lvl;

  uart_rx_frame_ctrl #(
    .DBITS(16), .MAX_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_TICKS(16)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .sample_tick (sample_tick),
    .out_if      (bus.master),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .err_code    (err_code),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) begin
    #2;
    if (tog_en) tog = ~tog;
  end

  // Inputs change at posedge+2, so the negedge sees what the next edge will act on.
  always @(negedge clk_100MHz) begin
    if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
    if (bus.out_valid) valid_seen = 1'b1;
    if (frame_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int idx, input logic [16:0] exp);
    logic [16:0] obs;
    obs = (idx < got_q.size()) ? got_q[idx] : 17'bx;
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  task automatic send(input logic [15:0] w);
    @(posedge clk_100MHz); #2;
    rx_data  = w;
    rx_ready = 1'b1;
    @(posedge clk_100MHz); #2;
    rx_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_100MHz); #2;
    sample_tick = 1'b1;
    @(posedge clk_100MHz); #2;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_100MHz);
    #2;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_last",  32'(bus.out_last), 0);
    check("rst_data",  32'(bus.out_data), 0);
    check("rst_done",  32'(frame_done), 0);
    check("rst_err",   32'(frame_error), 0);
    check("rst_code",  32'(err_code), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_drop",  32'(drop_cnt), 0);
    reset_n = 1'b1;
    idle(2);

    // Good frame
    rdy_lvl = 1'b1;
    send(16'hA502);
    check("good_busy", 32'(busy), 1);
    send(16'h1234);
    send(16'h0001);
    check("good_no_valid_early", 32'(bus.out_valid), 0);
    send(16'h1235);
    check("good_done",  32'(frame_done), 1);
    check("good_valid", 32'(bus.out_valid), 1);
    check("good_err",   32'(frame_error), 0);
    idle(5);
    check("good_done_once", 32'(done_cnt), 1);
    check("good_nwords", 32'(got_q.size()), 2);
    check_q("good_w0", 0, {1'b0, 16'h1234});
    check_q("good_w1", 1, {1'b1, 16'h0001});
    check("good_idle", 32'(busy), 0);

    // Bad checksum
    got_q.delete();
    valid_seen = 1'b0;
    send(16'hA502);
    send(16'h1234);
    send(16'h0001);
    send(16'hFFFF);
    check("csum_err",  32'(frame_error), 1);
    check("csum_code", 32'(err_code), 2);
    check("csum_done", 32'(frame_done), 0);
    idle(4);
    check("csum_count", 32'(dut.fifo_count), 0);
    check("csum_never_valid", 32'(valid_seen), 0);
    check("csum_nwords", 32'(got_q.size()), 0);
    check("csum_code_hold", 32'(err_code), 2);

    // Bad length and noise
    send(16'hA500);
    check("len0_err",  32'(frame_error), 1);
    check("len0_code", 32'(err_code), 0);
    check("len0_busy", 32'(busy), 0);
    send(16'hA509);
    check("len9_err",  32'(frame_error), 1);
    check("len9_code", 32'(err_code), 0);
    check("len9_busy", 32'(busy), 0);
    repeat (3) send(16'h5555);
    check("noise_drop", 32'(drop_cnt), 3);
    check("noise_busy", 32'(busy), 0);
    check("noise_err",  32'(frame_error), 0);

    // Overflow: a committed full FIFO, then a frame that cannot fit
    rdy_lvl = 1'b0;
    got_q.delete();
    send(16'hA508);
    for (int i = 1; i <= 8; i++) send(16'h1000 + 16'(i));
    send(16'h8024);
    check("ovf_first_done", 32'(frame_done), 1);
    check("ovf_count8", 32'(dut.fifo_count), 8);
    send(16'hA501);
    send(16'h7777);
    check("ovf_err",   32'(frame_error), 1);
    check("ovf_code",  32'(err_code), 1);
    check("ovf_busy",  32'(busy), 0);
    check("ovf_keep8", 32'(dut.fifo_count), 8);
    rdy_lvl = 1'b1;
    idle(12);
    check("ovf_nwords", 32'(got_q.size()), 8);
    for (int i = 0; i < 8; i++)
      check_q($sformatf("ovf_w%0d", i), i, {(i == 7), 16'h1001 + 16'(i)});

    // Back-to-back frames, consumer toggling, checksum wrap
    got_q.delete();
    done_cnt = 0;
    tog_en = 1'b1;
    send(16'hA503); send(16'hFFFF); send(16'hFFFF); send(16'h0003);
    send(16'h0001);
    send(16'hA503); send(16'h8000); send(16'h8000); send(16'h1234);
    send(16'h1234);
    idle(20);
    tog_en = 1'b0;
    check("b2b_done", 32'(done_cnt), 2);
    check("b2b_nwords", 32'(got_q.size()), 6);
    check_q("b2b_w0", 0, {1'b0, 16'hFFFF});
    check_q("b2b_w1", 1, {1'b0, 16'hFFFF});
    check_q("b2b_w2", 2, {1'b1, 16'h0003});
    check_q("b2b_w3", 3, {1'b0, 16'h8000});
    check_q("b2b_w4", 4, {1'b0, 16'h8000});
    check_q("b2b_w5", 5, {1'b1, 16'h1234});

    // Stalled frame
    got_q.delete();
    send(16'hA503);
    send(16'h0011);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (15) tick();
    check("tmo_early_err",  32'(frame_error), 0);
    check("tmo_early_busy", 32'(busy), 1);
    tick();
    check("tmo_err",  32'(frame_error), 1);
    check("tmo_code", 32'(err_code), 3);
    check("tmo_busy", 32'(busy), 0);
`else
    repeat (20) tick();
    check("stall_err",  32'(frame_error), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_code", 32'(err_code), 1);
`endif

    // Reset mid-frame with a committed frame waiting
    rdy_lvl = 1'b0;
    idle(2);
    reset_n = 1'b0; idle(1); reset_n = 1'b1; idle(1);
    send(16'hA501); send(16'h4321); send(16'h4321);
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    send(16'hA502); send(16'h0005);
    check("pre_rst_busy", 32'(busy), 1);
    send(16'h5555);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_data",  32'(bus.out_data), 0);
    check("mid_rst_last",  32'(bus.out_last), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_drop",  32'(drop_cnt), 0);
    check("mid_rst_code",  32'(err_code), 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_count", 32'(dut.fifo_count), 0);
    send(16'hA501); send(16'h0009); send(16'h0009);
    check("post_rst_done", 32'(frame_done), 1);
    check("post_rst_data", 32'(bus.out_data), 32'h0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
